// File: rtl/fsm_bit_serializer_if.sv
// Word-in / bit-out bundle between a word source and fsm_bit_serializer.
// The source drives data_in/data_valid; the serializer drives everything else.
interface fsm_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             underrun;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  bit_out,
        input  bit_valid,
        input  busy,
        input  underrun
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output bit_out,
        output bit_valid,
        output busy,
        output underrun
    );
endinterface

// File: rtl/fsm_bit_serializer.sv
// Parallel-in/serial-out feeder for the sequence detector: one shifter plus a
// one-word holding register so consecutive words stream without a gap.
module fsm_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    fsm_bit_serializer_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hfull;
    logic [CNT_W-1:0] r_cnt;
    logic             r_underrun;

    logic             w_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_shifting;
    logic             w_head_bit;
    logic [WIDTH-1:0] w_shift_adv;

    // Output end of the shifter depends on bit order; shifting moves toward it.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head_bit  = r_shift[WIDTH-1];
            assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head_bit  = r_shift[0];
            assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_ready    = ~r_hfull & ~reset;
    assign w_accept   = bus.data_valid & w_ready;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_shifting = (r_state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_hold     <= '0;
            r_hfull    <= 1'b0;
            r_cnt      <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift <= bus.data_in;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_shift <= w_shift_adv;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_accept) begin
                            r_hold  <= bus.data_in;
                            r_hfull <= 1'b1;
                        end
                    end else if (r_hfull) begin
                        r_shift <= r_hold;
                        r_hfull <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        // Word arriving on the last bit reloads the shifter with no gap.
                        r_shift <= bus.data_in;
                        r_cnt   <= '0;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_underrun <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_ready = w_ready;
    assign bus.bit_out    = w_shifting ? w_head_bit : IDLE_BIT;
    assign bus.bit_valid  = w_shifting;
    assign bus.busy       = w_shifting | r_hfull;
    assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Drives two serializers (MSB-first/idle 0 and LSB-first/idle 1) with the same
// stimulus and compares each against a bit-queue model of the output stream.
module tb_fsm_bit_serializer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fsm_bit_serializer_if #(.WIDTH(8)) if_a ();
    fsm_bit_serializer_if #(.WIDTH(8)) if_b ();

    fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the not-yet-emitted bits of every accepted word, in emission order.
    bit mbuf [2][0:31];
    int mhead [2];
    int mlen  [2];
    bit mund  [2];
    bit macc  [2];
    int nacc  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit msb_of(input int k);
        return (k == 0);
    endfunction

    function automatic bit idle_of(input int k);
        return (k == 1);
    endfunction

    task automatic model_push(input int k, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            mbuf[k][(mhead[k] + mlen[k]) % 32] = msb_of(k) ? w[7-i] : w[i];
            mlen[k]++;
        end
    endtask

    task automatic check_dut(input int k, input logic rdy_unused, input logic bo,
                             input logic bv, input logic bz, input logic un);
        bit exp_bo;
        exp_bo = (mlen[k] > 0) ? mbuf[k][mhead[k]] : idle_of(k);
        chk($sformatf("d%0d.bit_out", k),   32'(bo), 32'(exp_bo));
        chk($sformatf("d%0d.bit_valid", k), 32'(bv), 32'(mlen[k] > 0));
        chk($sformatf("d%0d.busy", k),      32'(bz), 32'(mlen[k] > 0));
        chk($sformatf("d%0d.underrun", k),  32'(un), 32'(mund[k]));
    endtask

    // One clock: apply inputs, check data_ready, clock, advance model, check outputs.
    task automatic step(input bit rst, input bit v, input logic [7:0] d);
        bit exp_rdy;
        reset           = rst;
        if_a.data_valid = v;
        if_b.data_valid = v;
        if_a.data_in    = d;
        if_b.data_in    = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_rdy = !rst && (mlen[k] <= 8);
            chk($sformatf("d%0d.data_ready", k),
                32'((k == 0) ? if_a.data_ready : if_b.data_ready), 32'(exp_rdy));
            macc[k] = v && exp_rdy;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mlen[k]  = 0;
                mhead[k] = 0;
                mund[k]  = 1'b0;
            end else begin
                bit had;
                had = (mlen[k] > 0);
                if (had) begin
                    mhead[k] = (mhead[k] + 1) % 32;
                    mlen[k]--;
                end
                if (macc[k]) model_push(k, d);
                mund[k] = had && (mlen[k] == 0);
            end
        end
        if (macc[0] && !rst) nacc++;
        check_dut(0, if_a.data_ready, if_a.bit_out, if_a.bit_valid, if_a.busy, if_a.underrun);
        check_dut(1, if_b.data_ready, if_b.bit_out, if_b.bit_valid, if_b.busy, if_b.underrun);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic offer(input logic [7:0] w);
        int t;
        t = 0;
        do begin
            step(1'b0, 1'b1, w);
            t++;
        end while (!macc[0] && t < 40);
        chk("offer_accepted", 32'(macc[0]), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mhead[k] = 0;
            mlen[k]  = 0;
            mund[k]  = 1'b0;
            macc[k]  = 1'b0;
        end
        reset           = 1'b1;
        if_a.data_valid = 1'b0;
        if_b.data_valid = 1'b0;
        if_a.data_in    = '0;
        if_b.data_in    = '0;
        @(negedge clk);

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hFF);

        // Single word, then fill and a single underrun pulse; also 0x01 LSB-first case.
        step(1'b0, 1'b1, 8'hB2);
        idle(10);
        step(1'b0, 1'b1, 8'h01);
        idle(10);

        // Streaming with data_valid held high.
        offer(8'hA5);
        offer(8'h3C);
        offer(8'hFF);
        idle(20);

        // Direct load exactly on the last bit of the previous word.
        step(1'b0, 1'b1, 8'h12);
        idle(7);
        step(1'b0, 1'b1, 8'h3C);
        idle(10);

        // Reset mid-word while the holding register is full.
        step(1'b0, 1'b1, 8'hC3);
        step(1'b0, 1'b1, 8'h5A);
        idle(2);
        step(1'b1, 1'b1, 8'h77);
        idle(3);
        chk("reset_hold_drop.busy", 32'(if_a.busy), 32'd0);

        // Random traffic, biased toward 0x55, with occasional resets.
        nacc = 0;
        for (int c = 0; c < 20000 && nacc < 500; c++) begin
            bit r;
            bit v;
            logic [7:0] d;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom);
            step(r, v, d);
        end
        chk("random_words_done", 32'(nacc >= 500), 32'd1);
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
